// File: rtl/axis_stream_producer_if.sv
// AXI-Stream bundle driven by axis_stream_producer.
// master drives payload and valid; slave returns ready.
interface axis_stream_producer_if #(
    parameter int DATA_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_stream_producer.sv
// Descriptor-driven AXI-Stream source: buffers loaded beats and replays them with exact idle gaps.
// Define AXIS_PRODUCER_PRBS_GAP_EN to add an LFSR gap source selected by gap_mode.
module axis_stream_producer #(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 16,
    parameter int DELAY_WIDTH = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      load_tdata,
    input  logic [DATA_WIDTH/8-1:0]    load_tkeep,
    input  logic [DELAY_WIDTH-1:0]     load_delay,
    input  logic                       load_tlast,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       gap_mode,
    axis_stream_producer_if.master     m_axis,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       beats_sent,
    output logic [CNT_WIDTH-1:0]       packets_sent,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GAP     = 2'd1;
    localparam logic [1:0] S_SEND    = 2'd2;
    localparam logic [1:0] S_STARVED = 2'd3;

    logic [DATA_WIDTH-1:0]  mem_data  [DEPTH];
    logic [KW-1:0]          mem_keep  [DEPTH];
    logic [DELAY_WIDTH-1:0] mem_delay [DEPTH];
    logic                   mem_last  [DEPTH];

    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;

    logic [DATA_WIDTH-1:0]  head_data;
    logic [KW-1:0]          head_keep;
    logic [DELAY_WIDTH-1:0] head_delay, eff_delay, gap_cnt;
    logic                   head_last;

    logic [DATA_WIDTH-1:0]  hold_data, out_data;
    logic [KW-1:0]          hold_keep, out_keep;
    logic                   hold_last, out_last;

    logic [1:0] state, state_nx;
    logic       stop_pending, stop_req, fire, eval, gap_end;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign push  = load_valid && !full;
    assign pop   = eval;

    assign load_ready = !full;
    assign fifo_level = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]]  <= load_tdata;
            mem_keep[wr_ptr[AW-1:0]]  <= load_tkeep;
            mem_delay[wr_ptr[AW-1:0]] <= load_delay;
            mem_last[wr_ptr[AW-1:0]]  <= load_tlast;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign head_data  = mem_data[rd_ptr[AW-1:0]];
    assign head_keep  = mem_keep[rd_ptr[AW-1:0]];
    assign head_delay = mem_delay[rd_ptr[AW-1:0]];
    assign head_last  = mem_last[rd_ptr[AW-1:0]];

`ifdef AXIS_PRODUCER_PRBS_GAP_EN
    localparam logic [DELAY_WIDTH-1:0] PRBS_MASK = DELAY_WIDTH'(7);
    logic [15:0] lfsr;

    // x^16 + x^14 + x^13 + x^11 + 1, free-running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign eff_delay = gap_mode ? (lfsr[DELAY_WIDTH-1:0] & PRBS_MASK) : head_delay;
`else
    logic unused_gap_mode;
    assign unused_gap_mode = gap_mode;
    assign eff_delay       = head_delay;
`endif

    assign stop_req = stop || stop_pending;
    assign fire     = (state == S_SEND) && m_axis.tready;
    // Head is consumed on a handshake or while starved, unless a stop is taking effect.
    assign eval     = !empty && !stop_req && ((state == S_STARVED) || fire);
    assign gap_end  = (state == S_GAP) && !stop_req && (gap_cnt == DELAY_WIDTH'(1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start && !stop) state_nx = S_STARVED;
            S_GAP:     if (stop_req) state_nx = S_IDLE;
                       else if (gap_end) state_nx = S_SEND;
            S_SEND:    if (fire) begin
                           if (stop_req)    state_nx = S_IDLE;
                           else if (eval)   state_nx = (eff_delay == '0) ? S_SEND : S_GAP;
                           else             state_nx = S_STARVED;
                       end
            S_STARVED: if (stop_req) state_nx = S_IDLE;
                       else if (eval) state_nx = (eff_delay == '0) ? S_SEND : S_GAP;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (eval) begin
            hold_data <= head_data;
            hold_keep <= head_keep;
            hold_last <= head_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            stop_pending <= 1'b0;
            gap_cnt      <= '0;
            out_data     <= '0;
            out_keep     <= '0;
            out_last     <= 1'b0;
            done         <= 1'b0;
            beats_sent   <= '0;
            packets_sent <= '0;
        end else begin
            state <= state_nx;

            if (state_nx == S_IDLE)
                stop_pending <= 1'b0;
            else if (stop && state != S_IDLE)
                stop_pending <= 1'b1;

            if (eval && eff_delay != '0)
                gap_cnt <= eff_delay;
            else if (state == S_GAP)
                gap_cnt <= gap_cnt - 1'b1;

            if (eval && eff_delay == '0) begin
                out_data <= head_data;
                out_keep <= head_keep;
                out_last <= head_last;
            end else if (gap_end) begin
                out_data <= hold_data;
                out_keep <= hold_keep;
                out_last <= hold_last;
            end else if (fire) begin
                out_data <= '0;
                out_keep <= '0;
                out_last <= 1'b0;
            end

            done <= fire && out_last;
            if (fire) begin
                beats_sent <= beats_sent + 1'b1;
                if (out_last) packets_sent <= packets_sent + 1'b1;
            end
        end
    end

    assign m_axis.tvalid = (state == S_SEND);
    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
    assign m_axis.tlast  = out_last;
    assign busy          = (state != S_IDLE);
endmodule

// File: doc/axis_stream_producer.md
Name: axis_stream_producer

Overview:
Parametrised AXI-Stream stimulus source for the AES-256-CTR benches and for on-chip traffic generation. The bench or a loader pushes descriptors through a load port: data, byte keep, per-beat idle-gap count and last flag. The block buffers them in an internal FIFO and replays them on a master AXI-Stream port with cycle-exact gaps and full backpressure compliance. It also provides start/stop control, packet/beat counters and a done pulse, and replaces file-driven producers wherever synthesizable or preloadable stimulus is needed.

Parameters:
DATA_WIDTH, 128, m_axis_tdata width; multiple of 8
DEPTH, 16, descriptor FIFO entries; power of 2, >= 2
DELAY_WIDTH, 8, width of per-beat gap count
CNT_WIDTH, 32, width of beat and packet counters

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
load_tdata  in  DATA_WIDTH  descriptor data
load_tkeep  in  DATA_WIDTH/8  descriptor byte enables
load_delay  in  DELAY_WIDTH  idle cycles before this beat
load_tlast  in  1  descriptor ends a packet
load_valid  in  1  descriptor push request
load_ready  out  1  FIFO not full
start  in  1  one-cycle pulse, begin/resume replay
stop  in  1  one-cycle pulse, halt after current beat
gap_mode  in  1  gap source select (see Optional Feature)
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tkeep  out  DATA_WIDTH/8  stream byte enables
m_axis_tlast  out  1  end of packet
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after each tlast handshake
beats_sent  out  CNT_WIDTH  accepted beats since reset
packets_sent  out  CNT_WIDTH  accepted tlast beats since reset
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all outputs 0 except load_ready=1. FIFO flushed, counters cleared, state IDLE. Reset mid-packet drops the beat in flight with no tlast.
- FIFO: read/write pointers with extra wrap bit. full when MSBs differ and low bits are equal; empty when pointers are equal.
  - Push on load_valid&&load_ready.
  - load_ready = !full. A push is refused when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave fifo_level unchanged.
- States IDLE, GAP, SEND, STARVED.
  - IDLE: tvalid=0, tdata/tkeep/tlast=0. On start go to STARVED; if the FIFO is non-empty, evaluate the head in the same cycle.
  - Head evaluation: pop head. If its effective delay is 0, register it to the outputs and go to SEND. Otherwise load gap_cnt=delay, hold the entry and go to GAP.
  - GAP: tvalid=0; gap_cnt decrements each cycle. When gap_cnt==1, register the held entry and go to SEND. A delay of d gives exactly d tvalid-low cycles.
  - SEND: tvalid=1. tdata/tkeep/tlast are stable while !tready; tvalid is never withdrawn before the handshake. On handshake:
    - beats_sent++; if tlast, packets_sent++ and done=1 the next cycle.
    - If a stop is pending, go to IDLE.
    - Otherwise, if the FIFO is non-empty, evaluate the head. Delay 0 gives a back-to-back beat with zero bubble.
    - Otherwise go to STARVED.
  - STARVED: tvalid=0; evaluate the head as soon as the FIFO is non-empty. A descriptor pushed at edge N with delay 0 has tvalid high after edge N+1.
- Latency: start sampled at edge N with head delay d: tvalid rises after edge N+1+d.
- stop: latched as stop_pending.
  - In GAP or STARVED: go to IDLE next cycle; a held entry is discarded.
  - In SEND: wait for the handshake.
  - In IDLE: ignored.
- Simultaneous start+stop: stop wins.
- Counters wrap modulo 2^CNT_WIDTH.

Optional Feature:
- Macro: AXIS_PRODUCER_PRBS_GAP_EN.
- Defined: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every clk. When gap_mode=1, the effective delay = lfsr[DELAY_WIDTH-1:0] & 8'h07 (0..7), ignoring load_delay.
- Not defined: gap_mode is ignored, load_delay is always used, and no LFSR logic exists.

Test Plan:
- Push 4 beats (delay 0, tlast on 4th), tready=1, start -> tvalid high 4 consecutive cycles starting 1 cycle after start; tlast on beat 4; done one cycle later; beats_sent=4, packets_sent=1.
- Beat delays 0,3,0,5 -> exactly 0,3,0,5 tvalid-low cycles before the respective beats.
- tready low for 7 cycles mid-packet -> tdata/tkeep/tlast held constant and tvalid stays 1; no beat lost or duplicated.
- Fill FIFO to 16 -> load_ready=0 and fifo_level=16; a push attempt while full is rejected even with a simultaneous pop; fifo_level=15 after one pop.
- stop asserted during the handshake-stalled 2nd beat -> that beat completes, then IDLE with tvalid=0 and 2 entries remaining; start resumes with the 3rd beat.
- rst_n asserted mid-GAP -> outputs 0 immediately (async), load_ready=1, fifo_level=0, counters 0.
